// File: rtl/usb_pkg.sv
// Shared USB definitions: CRC5 constants, TX CRC5 state type, and the
// single next-remainder function used by both the RX checker and TX generator.
package usb_pkg;

  localparam logic [4:0]  CRC5_INIT      = 5'b11111;
  localparam logic [4:0]  CRC5_POLY      = 5'b00101;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam int unsigned TOKEN_CRC_BITS = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2,
    DONE = 2'd3
  } crc5_tx_state_t;

  // One serial CRC5 step: shift left, fold in the taps when the outgoing
  // MSB differs from the incoming bit.
  function automatic logic [4:0] crc5_step(
    input logic [4:0] crc,
    input logic       b,
    input logic [4:0] poly = CRC5_POLY
  );
    logic fb;
    fb = crc[4] ^ b;
    return {crc[3:0], 1'b0} ^ (fb ? poly : 5'b00000);
  endfunction

endpackage

// File: rtl/crc5_tx.sv
// Transmit-side USB CRC5 generator/appender. Payload bits pass straight
// through to the encoder while the remainder accumulates; the inverted
// remainder is then shifted out MSB first. The encoder paces every bit
// with shift_en.
module crc5_tx
  import usb_pkg::*;
#(
  parameter int unsigned DATA_BITS = TOKEN_CRC_BITS,
  parameter logic [4:0]  CRC_INIT  = CRC5_INIT,
  parameter logic [4:0]  CRC_POLY  = CRC5_POLY
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start,
  input  logic abort,
  input  logic shift_en,
  input  logic data_bit,
  output logic tx_bit,
  output logic crc_phase,
  output logic data_req,
  output logic busy,
  output logic done
);

  localparam logic [4:0] LAST_DATA = 5'(DATA_BITS - 1);
  localparam logic [4:0] LAST_CRC  = 5'd4;

  if (DATA_BITS < 5 || DATA_BITS > 31) begin : g_bad_data_bits
    $error("crc5_tx: DATA_BITS must be in 5..31");
  end

  crc5_tx_state_t state;
  logic [4:0]     crc;
  logic [4:0]     cnt;

  // Frame sequencer and remainder register; abort overrides everything.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      crc   <= CRC_INIT;
      cnt   <= '0;
    end else if (abort) begin
      state <= IDLE;
      crc   <= CRC_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            crc   <= CRC_INIT;
            cnt   <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (shift_en) begin
            crc <= crc5_step(crc, data_bit, CRC_POLY);
            if (cnt == LAST_DATA) begin
              cnt   <= '0;
              state <= CRC;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        CRC: begin
          if (shift_en) begin
            crc <= {crc[3:0], 1'b0};
            cnt <= cnt + 5'd1;
            if (cnt == LAST_CRC) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          crc   <= CRC_INIT;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          crc   <= CRC_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output decode; tx_bit in DATA is a zero-latency pass-through.
  always_comb begin
    tx_bit    = 1'b0;
    crc_phase = 1'b0;
    data_req  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      DATA: begin
        tx_bit   = data_bit;
        data_req = 1'b1;
        busy     = 1'b1;
      end
      CRC: begin
        tx_bit    = ~crc[4];
        crc_phase = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_crc5_tx.sv
// Self-checking bench for crc5_tx: scoreboard of expected tx_bit values,
// plus an independent RX-side CRC5 loopback on the bits actually sent.
module tb_crc5_tx;

  logic clk = 1'b0;
  logic n_rst, start, abort, shift_en, data_bit;
  logic tx_bit, crc_phase, data_req, busy, done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        exp_q[$];
  logic [4:0]  rx_crc;
  logic [4:0]  crc_bits;

  crc5_tx #(
    .DATA_BITS(11),
    .CRC_INIT (5'b11111),
    .CRC_POLY (5'b00101)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .abort    (abort),
    .shift_en (shift_en),
    .data_bit (data_bit),
    .tx_bit   (tx_bit),
    .crc_phase(crc_phase),
    .data_req (data_req),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference CRC5 (x^5+x^2+1) written as explicit per-bit LFSR equations.
  function automatic logic [4:0] ref_step(input logic [4:0] c, input logic b);
    logic fb;
    fb = c[4] ^ b;
    return {c[3], c[2], c[1] ^ fb, c[0], fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [10:0] p);
    logic [4:0] c;
    c = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(p[i]);
      c = ref_step(c, p[i]);
    end
    for (int k = 4; k >= 0; k--) exp_q.push_back(~c[k]);
  endtask

  // Apply inputs at the falling edge and sample 1 time unit later.
  task automatic drive(input logic st, input logic sh, input logic ab, input logic b);
    @(negedge clk);
    start = st; shift_en = sh; abort = ab; data_bit = b;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'($urandom));
      chk("gap_busy", busy, 1);
      chk("gap_done", done, 0);
    end
  endtask

  task automatic strobe(input logic b, input logic st, input logic ab, output logic obs);
    logic e;
    drive(st, 1'b1, ab, b);
    if (data_req || crc_phase) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("tx_bit", tx_bit, e);
      end
      rx_crc = ref_step(rx_crc, tx_bit);
    end
    chk("done_early", done, 0);
    obs = tx_bit;
  endtask

  task automatic run_frame(input logic [10:0] p, input int unsigned every,
                           input int unsigned mid_gap, input logic st_mid,
                           input logic st_shift, output logic [4:0] bits);
    logic obs;
    push_frame(p);
    rx_crc = 5'b11111;
    bits   = '0;
    drive(1'b1, st_shift, 1'b0, 1'b1);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) idle(every - 1);
      if (i == 6) idle(mid_gap);
      strobe((i < 11) ? p[i] : 1'($urandom), st_mid && (i == 3), 1'b0, obs);
      if (i >= 11) bits[15 - i] = obs;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_pulse", done, 1);
    chk("residual", rx_crc, 5'b01100);
    chk("sb_empty", exp_q.size(), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_single", done, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic obs;
    logic [10:0] pay;
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; shift_en = 1'b0; data_bit = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", {tx_bit, crc_phase, data_req, busy, done}, 5'b0);
    n_rst = 1'b1;

    // All-zero token, one strobe per cycle.
    run_frame(11'h000, 1, 0, 1'b0, 1'b0, crc_bits);
    chk("zero_crc_bits", crc_bits, 5'b01000);

    // Same payload, strobe every 3rd cycle plus a 7-cycle gap mid-DATA.
    run_frame(11'h000, 3, 7, 1'b0, 1'b0, crc_bits);
    chk("gapped_crc_bits", crc_bits, 5'b01000);

    // start during DATA ignored; shift_en coinciding with start not counted.
    run_frame(11'h5a3, 1, 0, 1'b1, 1'b1, crc_bits);

    // Abort on the 3rd CRC bit.
    pay = 11'h2c7;
    push_frame(pay);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) strobe((i < 11) ? pay[i] : 1'b0, 1'b0, 1'b0, obs);
    strobe(1'b0, 1'b0, 1'b1, obs);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_crc_phase", crc_phase, 0);
    exp_q.delete();
    run_frame(11'h3e1, 1, 0, 1'b0, 1'b0, crc_bits);

    // Reset mid-frame.
    pay = 11'h155;
    push_frame(pay);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) strobe(pay[i], 1'b0, 1'b0, obs);
    @(negedge clk);
    n_rst = 1'b0; shift_en = 1'b1; data_bit = 1'b1;
    #1;
    chk("midreset_outs", {tx_bit, crc_phase, data_req, busy, done}, 5'b0);
    @(negedge clk);
    shift_en = 1'b0; n_rst = 1'b1;
    #1;
    chk("postreset_outs", {tx_bit, crc_phase, data_req, busy, done}, 5'b0);
    exp_q.delete();
    run_frame(11'h000, 1, 0, 1'b0, 1'b0, crc_bits);
    chk("postreset_crc_bits", crc_bits, 5'b01000);

    // Random loopback frames.
    for (int f = 0; f < 1000; f++) begin
      run_frame(11'($urandom), 1 + ((f % 7 == 0) ? 1 : 0), 0, 1'b0, 1'($urandom), crc_bits);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
